// File: rtl/free_list_multi.sv
// Multi-lane physical register free list with checkpoint/restore.
// Grants the lowest free registers per lane; free strobes also update every checkpoint.
module free_list_multi #(
  parameter int NUM_PREGS = 64,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  parameter int NUM_CKPT  = 4,
  localparam int PW = $clog2(NUM_PREGS),
  localparam int CW = $clog2(NUM_CKPT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ALLOC_W-1:0]      alloc_req,
  output logic [ALLOC_W-1:0]      alloc_valid,
  output logic [ALLOC_W*PW-1:0]   alloc_preg,
  input  logic [FREE_W-1:0]       free_valid,
  input  logic [FREE_W*PW-1:0]    free_preg,
  input  logic                    ckpt_save,
  input  logic [CW-1:0]           ckpt_id,
  input  logic                    ckpt_restore,
  input  logic [CW-1:0]           restore_id,
  output logic [PW:0]             free_count,
  output logic                    empty,
  output logic                    double_free
);

  localparam logic [NUM_PREGS-1:0] RESET_MAP = {{(NUM_PREGS-1){1'b1}}, 1'b0};
  localparam logic [PW:0]          RESET_CNT = (PW+1)'(NUM_PREGS-1);

  logic [NUM_PREGS-1:0] bitmap_q, bitmap_d;
  logic [NUM_PREGS-1:0] ckpt_q [NUM_CKPT];
  logic [NUM_PREGS-1:0] ckpt_d [NUM_CKPT];
  logic [ALLOC_W-1:0]    alloc_valid_q, alloc_valid_d;
  logic [ALLOC_W*PW-1:0] alloc_preg_q, alloc_preg_d;
  logic [PW:0]           free_count_q, free_count_d;
  logic                  empty_q, empty_d;
  logic                  double_free_q, double_free_d;

  logic [NUM_PREGS-1:0] avail;
  logic [NUM_PREGS-1:0] free_mask;
  logic                 found;
  logic                 dbl;
  logic [PW-1:0]        idx;

  // NOTE: blocking assignments here are deliberate; avail is consumed lane by
  // lane so each lane sees the registers already taken by lower lanes.
  always_comb begin
    avail         = bitmap_q;
    alloc_valid_d = '0;
    alloc_preg_d  = '0;
    found         = 1'b0;
    for (int k = 0; k < ALLOC_W; k++) begin
      found = 1'b0;
      if (alloc_req[k] && !ckpt_restore) begin
        for (int i = 1; i < NUM_PREGS; i++) begin
          if (!found && avail[i]) begin
            found                    = 1'b1;
            alloc_valid_d[k]         = 1'b1;
            alloc_preg_d[k*PW +: PW] = PW'(i);
            avail[i]                 = 1'b0;
          end
        end
      end
    end
  end

  // P0 is never freed; a repeat within the cycle or of an already-free bit is an error.
  always_comb begin
    free_mask = '0;
    dbl       = 1'b0;
    idx       = '0;
    for (int j = 0; j < FREE_W; j++) begin
      idx = free_preg[j*PW +: PW];
      if (free_valid[j] && (idx != '0)) begin
        if (bitmap_q[idx] || free_mask[idx]) dbl = 1'b1;
        free_mask[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    if (ckpt_restore) bitmap_d = ckpt_q[restore_id] | free_mask;
    else              bitmap_d = avail | free_mask;

    for (int s = 0; s < NUM_CKPT; s++) begin
      ckpt_d[s] = ckpt_q[s] | free_mask;
      if (ckpt_save && !ckpt_restore && (CW'(s) == ckpt_id)) ckpt_d[s] = bitmap_d;
    end

    free_count_d = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      free_count_d = free_count_d + {{PW{1'b0}}, bitmap_d[i]};
    end
    empty_d       = (free_count_d == '0);
    double_free_d = double_free_q | dbl;
  end

  // NOTE: checkpoint slots are state that later restores read, so they are
  // reset like the live bitmap rather than left undefined.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap_q      <= RESET_MAP;
      for (int s = 0; s < NUM_CKPT; s++) ckpt_q[s] <= RESET_MAP;
      alloc_valid_q <= '0;
      alloc_preg_q  <= '0;
      free_count_q  <= RESET_CNT;
      empty_q       <= 1'b0;
      double_free_q <= 1'b0;
    end else begin
      bitmap_q      <= bitmap_d;
      for (int s = 0; s < NUM_CKPT; s++) ckpt_q[s] <= ckpt_d[s];
      alloc_valid_q <= alloc_valid_d;
      alloc_preg_q  <= alloc_preg_d;
      free_count_q  <= free_count_d;
      empty_q       <= empty_d;
      double_free_q <= double_free_d;
    end
  end

  assign alloc_valid = alloc_valid_q;
  assign alloc_preg  = alloc_preg_q;
  assign free_count  = free_count_q;
  assign empty       = empty_q;
  assign double_free = double_free_q;

endmodule

// File: tb/tb_free_list_multi.sv
// Directed bench for free_list_multi at default parameters.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_free_list_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alloc_req;
  logic [1:0]  alloc_valid;
  logic [11:0] alloc_preg;
  logic [1:0]  free_valid;
  logic [11:0] free_preg;
  logic        ckpt_save;
  logic [1:0]  ckpt_id;
  logic        ckpt_restore;
  logic [1:0]  restore_id;
  logic [6:0]  free_count;
  logic        empty;
  logic        double_free;

  int n_checks = 0;
  int n_errors = 0;

  free_list_multi dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_preg   (alloc_preg),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .ckpt_save    (ckpt_save),
    .ckpt_id      (ckpt_id),
    .ckpt_restore (ckpt_restore),
    .restore_id   (restore_id),
    .free_count   (free_count),
    .empty        (empty),
    .double_free  (double_free)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    reset        = 1'b0;
    alloc_req    = 2'b00;
    free_valid   = 2'b00;
    free_preg    = '0;
    ckpt_save    = 1'b0;
    ckpt_id      = '0;
    ckpt_restore = 1'b0;
    restore_id   = '0;
  endtask

  // One rising edge with the currently driven inputs, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    do_reset();
    check("rst_count", free_count, 63);
    check("rst_empty", empty, 0);
    check("rst_dbl", double_free, 0);
    check("rst_valid", alloc_valid, 0);
    check("rst_preg", alloc_preg, 0);

    // Two-lane grant from reset
    alloc_req = 2'b11; tick();
    check("a11_valid", alloc_valid, 2'b11);
    check("a11_lane0", alloc_preg[5:0], 1);
    check("a11_lane1", alloc_preg[11:6], 2);
    check("a11_count", free_count, 61);
    tick();
    check("hold_one_cycle", alloc_valid, 0);

    // Only lane 1 requests
    alloc_req = 2'b10; tick();
    check("l1_valid", alloc_valid, 2'b10);
    check("l1_lane0_zero", alloc_preg[5:0], 0);
    check("l1_lane1", alloc_preg[11:6], 3);
    check("l1_count", free_count, 60);

    // Drain P4..P61, then P62, leaving only P63
    for (int c = 0; c < 29; c++) begin
      alloc_req = 2'b11; tick();
    end
    check("drain_lane1", alloc_preg[11:6], 61);
    alloc_req = 2'b01; tick();
    check("last_but_one", alloc_preg[5:0], 62);
    check("one_left_count", free_count, 1);
    check("one_left_empty", empty, 0);

    alloc_req = 2'b11; tick();
    check("partial_valid", alloc_valid, 2'b01);
    check("partial_lane0", alloc_preg[5:0], 63);
    check("partial_lane1", alloc_preg[11:6], 0);
    check("partial_empty", empty, 1);
    check("partial_count", free_count, 0);

    // Free with same-cycle request: no bypass
    free_valid = 2'b01; free_preg = {6'd0, 6'd5}; alloc_req = 2'b01; tick();
    check("nobypass_valid", alloc_valid, 0);
    check("nobypass_count", free_count, 1);
    check("nobypass_empty", empty, 0);
    alloc_req = 2'b01; tick();
    check("realloc_valid", alloc_valid, 2'b01);
    check("realloc_preg", alloc_preg[5:0], 5);
    check("realloc_empty", empty, 1);

    // Checkpoint save / restore
    do_reset();
    alloc_req = 2'b11; tick();
    alloc_req = 2'b11; tick();
    check("ck_p4", alloc_preg[11:6], 4);
    ckpt_save = 1'b1; ckpt_id = 2'd2; tick();
    check("ck_save_count", free_count, 59);
    alloc_req = 2'b11; tick();
    alloc_req = 2'b11; tick();
    check("ck_p7", alloc_preg[5:0], 7);
    check("ck_p8", alloc_preg[11:6], 8);
    check("ck_alloc_count", free_count, 55);
    free_valid = 2'b01; free_preg = {6'd0, 6'd3}; tick();
    check("ck_free_count", free_count, 56);
    ckpt_restore = 1'b1; restore_id = 2'd2; alloc_req = 2'b11;
    ckpt_save = 1'b1; ckpt_id = 2'd1; tick();
    check("restore_valid", alloc_valid, 0);
    check("restore_count", free_count, 60);
    alloc_req = 2'b01; tick();
    check("restore_p3", alloc_preg[5:0], 3);
    alloc_req = 2'b11; tick();
    check("restore_p5", alloc_preg[5:0], 5);
    check("restore_p6", alloc_preg[11:6], 6);

    // Double free and P0 free
    do_reset();
    free_valid = 2'b01; free_preg = {6'd0, 6'd7}; tick();
    check("dbl_set", double_free, 1);
    check("dbl_count", free_count, 63);
    tick();
    check("dbl_sticky", double_free, 1);
    free_valid = 2'b10; free_preg = {6'd0, 6'd0}; tick();
    check("p0_count", free_count, 63);
    do_reset();
    check("dbl_cleared", double_free, 0);
    free_valid = 2'b01; free_preg = {6'd0, 6'd0}; tick();
    check("p0_not_dbl", double_free, 0);
    alloc_req = 2'b11; tick();
    free_valid = 2'b11; free_preg = {6'd1, 6'd1}; tick();
    check("dup_lane_dbl", double_free, 1);
    check("dup_lane_count", free_count, 62);

    // Reset wins over same-cycle requests and restore
    reset = 1'b1; alloc_req = 2'b11; ckpt_restore = 1'b1; restore_id = 2'd2; tick();
    check("rstprio_valid", alloc_valid, 0);
    check("rstprio_count", free_count, 63);
    check("rstprio_dbl", double_free, 0);
    check("rstprio_empty", empty, 0);
    alloc_req = 2'b01; tick();
    check("rstprio_p1", alloc_preg[5:0], 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
